// File: rtl/cost_arb_pkg.sv
// rtl/cost_arb_pkg.sv - shared widths and owner-state encoding for cost_arb
//
// Purpose : common definitions for the cost-table arbiter and its picker.
// Contents: IDX_W  - width of worker/job index
//           COST_W - width of a cost-table entry
//           NREQ   - number of requesters
//           own_state_e - burst-ownership FSM states
package cost_arb_pkg;

  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  localparam int NREQ   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } own_state_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker
//
// Purpose : picks at most one winner among two requesters.
// Ports   : req_i  [NREQ] - raw request vector
//           mask_i [NREQ] - eligibility mask (owner lock narrows this)
//           last_i        - last granted requester index
//           win_o  [NREQ] - one-hot-or-zero winner
module rr_pick2
  import cost_arb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  input  logic            last_i,
  output logic [NREQ-1:0] win_o
);

  logic [NREQ-1:0] eff;

  assign eff = req_i & mask_i;

  // Contention goes to whoever was not granted last; otherwise the lone
  // eligible requester (or nobody) wins.
  always_comb begin
    win_o = eff;
    if (eff == 2'b11) begin
      win_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cost_arb.sv
// rtl/cost_arb.sv - two-requester round-robin arbiter for a shared cost table
//
// Purpose : grants one requester per cycle access to a combinational cost
//           table and returns the looked-up cost one cycle later.
// Config  : COST_ARB_LOCK_EN - compiles in burst ownership (LOCK input);
//           without it LOCK is ignored and arbitration is per-cycle.
// Ports   : CLK, RST            - clock, asynchronous active-high reset
//           REQ [2]             - per-requester request
//           W0/J0, W1/J1 [3]    - worker/job index per requester
//           LOCK [2]            - per-requester hold-ownership request
//           GNT [2]             - combinational one-hot-or-zero grant
//           W, J [3]            - table address of the granted requester
//           Cost [7]            - table data, valid with W/J
//           RDATA [7], RVALID[2]- registered cost and its owner
module cost_arb
  import cost_arb_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [IDX_W-1:0]  W0,
  input  logic [IDX_W-1:0]  J0,
  input  logic [IDX_W-1:0]  W1,
  input  logic [IDX_W-1:0]  J1,
  input  logic [NREQ-1:0]   LOCK,
  output logic [NREQ-1:0]   GNT,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic [COST_W-1:0] RDATA,
  output logic [NREQ-1:0]   RVALID
);

  own_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [COST_W-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]   rvalid_q;
  logic [NREQ-1:0]   mask;
  logic [NREQ-1:0]   win;
  logic [NREQ-1:0]   gnt;

  // An owner holds the table exclusively for the whole burst, including the
  // release cycle where it has dropped REQ (nobody is granted then).
  always_comb begin
    case (state_q)
      ST_OWN0: mask = 2'b01;
      ST_OWN1: mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  rr_pick2 u_pick (
    .req_i  (REQ),
    .mask_i (mask),
    .last_i (last_q),
    .win_o  (win)
  );

  // Grant is suppressed combinationally while reset is asserted.
  assign gnt = RST ? '0 : win;
  assign GNT = gnt;

  always_comb begin
    W = '0;
    J = '0;
    if (gnt[1]) begin
      W = W1;
      J = J1;
    end else if (gnt[0]) begin
      W = W0;
      J = J0;
    end
  end

  assign rdata_d = (|gnt) ? Cost : rdata_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (|gnt) begin
      last_d = gnt[1];
    end
`ifdef COST_ARB_LOCK_EN
    case (state_q)
      ST_IDLE: begin
        if (gnt[0] && LOCK[0]) begin
          state_d = ST_OWN0;
        end else if (gnt[1] && LOCK[1]) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        // Leaving marks the owner as last so the other side wins next.
        if (!REQ[0] || !LOCK[0]) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!REQ[1] || !LOCK[1]) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    state_d = ST_IDLE;
`endif
  end

`ifndef COST_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^LOCK;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rdata_q  <= rdata_d;
      rvalid_q <= gnt;
    end
  end

  assign RDATA  = rdata_q;
  assign RVALID = rvalid_q;

endmodule

// File: doc/cost_arb.md
COST_ARB -- requirements
Module: cost_arb

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port REQ, input, 2, per-requester access request; bit i belongs to requester i.
REQ-004 SHALL have ports W0/J0 and W1/J1, input, 3 each, worker/job index from requester 0 and requester 1.
REQ-005 SHALL have port LOCK, input, 2, per-requester hold-ownership request for burst access.
REQ-006 SHALL have port GNT, output, 2, one-hot-or-zero grant for the current cycle.
REQ-007 SHALL have ports W and J, output, 3 each, address to the shared cost table.
REQ-008 SHALL have port Cost, input, 7, table data, combinationally valid in the same cycle as W/J.
REQ-009 SHALL have port RDATA, output, 7, registered returned cost.
REQ-010 SHALL have port RVALID, output, 2, one-hot-or-zero, marks RDATA owner.

Function
REQ-011 SHALL drive GNT combinationally from REQ, LOCK, owner state and priority pointer; at most one bit high.
REQ-012 SHALL drive W/J from the granted requester's W/J; 3'd0/3'd0 when GNT==0.
REQ-013 SHALL, at each edge, load RDATA<=Cost and RVALID<=GNT; read latency exactly 1 cycle, one beat per grant.
REQ-014 SHALL hold RDATA unchanged when GNT==0; RVALID goes 0.
REQ-015 SHALL arbitrate round-robin: pointer LAST records last granted requester; single requester always wins; both requesting -> the requester != LAST wins.
REQ-016 SHALL update LAST only on cycles with a grant.
REQ-017 SHALL implement owner FSM IDLE, OWN0, OWN1.
REQ-018 IDLE -> OWNi when GNT[i] && LOCK[i]; else stay IDLE.
REQ-019 In OWNi SHALL grant only requester i (other masked) whenever REQ[i]=1.
REQ-020 OWNi -> IDLE when REQ[i]=0, or REQ[i]=1 with LOCK[i]=0 (that final beat still granted to i).
REQ-021 SHALL set LAST=i on leaving OWNi, so the other requester wins next contention.
REQ-022 REQ[i]=0 while LOCK[i]=1 SHALL be treated as release; LOCK without REQ never grants.

Reset
REQ-023 RST=1 SHALL immediately force state IDLE, LAST=1, RDATA=0, RVALID=0.
REQ-024 GNT SHALL be 0 and W/J SHALL be 0 while RST=1.
REQ-025 Reset mid-burst SHALL drop ownership and discard any pending beat; first post-reset contention goes to requester 0.

Configuration
REQ-026 Macro COST_ARB_LOCK_EN SHALL compile in burst ownership (REQ-017..REQ-022).
REQ-027 Without COST_ARB_LOCK_EN: LOCK port present but ignored, FSM held in IDLE, pure per-cycle round-robin.

Structure
REQ-028 Package cost_arb_pkg SHALL hold widths (IDX_W=3, COST_W=7, NREQ=2) and the owner-state enum.
REQ-029 Sub-module rr_pick2 SHALL hold the 2-way round-robin picker (REQ, mask, LAST -> one-hot win).

Verification
REQ-030 Reset, then REQ=01, W0=2, J0=5, Cost=7'd40 -> GNT=01, W=2, J=5; next cycle RVALID=01, RDATA=40.
REQ-031 REQ=11 held 4 cycles after reset -> GNT sequence 01,10,01,10; RVALID follows one cycle later.
REQ-032 LOCK_EN: REQ=11, LOCK=01 for 8 cycles, LOCK=00 on 9th -> GNT=01 for 9 cycles, then 10.
REQ-033 No LOCK_EN: same stimulus as REQ-032 -> GNT alternates 01,10 from first cycle.
REQ-034 RST pulsed in OWN0 while REQ=11, LOCK=01 -> GNT/RVALID 0 during RST; after release, GNT=01 and FSM re-enters OWN0.
REQ-035 REQ=00 for 3 cycles after RDATA=40 -> GNT=00, W=J=0, RVALID=00, RDATA stays 40.
